// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issue/capture controller in front of the sequential mult (signed) and multu (unsigned) units.
// Ports: clk, reset (sync, active-low); req_* valid/ready request with operands and signedness;
// mul_a/mul_b/mul_do/mul_rst drive both units; done_s/out_s from mult, done_u/out_u from multu;
// rsp_* valid/ready response (rsp_err flags a timeout abort); busy is high outside IDLE.
// Optional: define MULT_ISSUE_CTRL_PERF_EN to add last_lat, the WAIT cycle count of the last operation.
module mult_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int DATA_W = 32,
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic              mul_do,
  output logic              mul_rst,
  input  logic              done_s,
  input  logic              done_u,
  input  logic [DATA_W-1:0] out_s,
  input  logic [DATA_W-1:0] out_u,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
`ifdef MULT_ISSUE_CTRL_PERF_EN
  ,
  output logic [15:0]       last_lat
`endif
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state;
  logic sel, armed, done;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  assign done = sel ? done_s : done_u;
  assign cnt_nx = cnt + 1'b1;
  assign req_ready = (state == IDLE) && reset;
  // armed only sets after done has been seen low, so a done left high by the previous operation is never taken
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
      mul_do <= 1'b0;
      mul_rst <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      armed <= 1'b0;
      sel <= 1'b0;
`ifdef MULT_ISSUE_CTRL_PERF_EN
      last_lat <= '0;
`endif
    end else begin
      mul_rst <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          mul_a <= req_a;
          mul_b <= req_b;
          sel <= req_signed;
          mul_do <= 1'b1;
          busy <= 1'b1;
          state <= LAUNCH;
        end
        LAUNCH: begin
          mul_do <= 1'b0;
          cnt <= '0;
          armed <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (!done) armed <= 1'b1;
          if (armed && done) begin
            rsp_data <= sel ? out_s : out_u;
            rsp_err <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RESP;
`ifdef MULT_ISSUE_CTRL_PERF_EN
            last_lat <= 16'(cnt_nx);
`endif
          end else begin
            cnt <= cnt_nx;
            if (cnt_nx == CW'(TIMEOUT_CYCLES)) begin
              rsp_data <= '0;
              rsp_err <= 1'b1;
              mul_rst <= 1'b1;
              rsp_valid <= 1'b1;
              state <= RESP;
`ifdef MULT_ISSUE_CTRL_PERF_EN
              last_lat <= 16'(cnt_nx);
`endif
            end
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: directed self-checking bench for mult_issue_ctrl with behavioural mult/multu models
module tb_mult_issue_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic req_signed = 1'b0;
  logic rsp_ready = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic req_ready, mul_do, mul_rst, rsp_valid, rsp_err, busy, done_s, done_u;
  logic [31:0] mul_a, mul_b, out_s, out_u, rsp_data;
`ifdef MULT_ISSUE_CTRL_PERF_EN
  logic [15:0] last_lat;
`endif
  logic ds = 1'b0, du = 1'b0, bs = 1'b0, bu = 1'b0;
  logic stale_s = 1'b0, force_u = 1'b0, hang = 1'b0;
  logic [31:0] os = '0, ou = '0, ps = '0, pu = '0, u_xor = '0;
  int cs = 0, cu = 0, lat = 64;
  int checks = 0, failures = 0, cyc = 0, do_cnt = 0, busy_bad = 0, stable = 0;
  assign done_s = ds | stale_s;
  assign done_u = du | force_u;
  assign out_s = os;
  assign out_u = ou ^ u_xor;
  mult_issue_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_do(mul_do), .mul_rst(mul_rst),
    .done_s(done_s), .done_u(done_u), .out_s(out_s), .out_u(out_u), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
`ifdef MULT_ISSUE_CTRL_PERF_EN
    , .last_lat(last_lat)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (mul_rst) begin ds <= 1'b0; bs <= 1'b0; end
    else if (mul_do) begin bs <= !hang; cs <= lat; ds <= 1'b0; ps <= mul_a * mul_b; end
    else if (bs) begin
      if (cs <= 1) begin ds <= 1'b1; bs <= 1'b0; os <= ps; end
      else cs <= cs - 1;
    end
  always @(posedge clk)
    if (mul_rst) begin du <= 1'b0; bu <= 1'b0; end
    else if (mul_do) begin bu <= !hang; cu <= lat; du <= 1'b0; pu <= mul_a * mul_b; end
    else if (bu) begin
      if (cu <= 1) begin du <= 1'b1; bu <= 1'b0; ou <= pu; end
      else cu <= cu - 1;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a = a;
    req_b = b;
    req_signed = s;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
  endtask
  task automatic wait_rsp;
    cyc = 0;
    do_cnt = 0;
    busy_bad = 0;
    while (!rsp_valid && cyc < 400) begin
      if (mul_do) do_cnt++;
      if (!busy) busy_bad++;
      tick;
      cyc++;
    end
  endtask
  task automatic respond;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("hs_valid", rsp_valid, 0);
    check("hs_ready", req_ready, 1);
  endtask
  initial begin
    repeat (3) tick;
    check("rst_ready", req_ready, 0);
    check("rst_mul_rst", mul_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_data", rsp_data, 0);
    check("rst_do", mul_do, 0);
    reset = 1'b1;
    tick;
    check("rel_mul_rst", mul_rst, 0);
    check("rel_ready", req_ready, 1);
    lat = 64;
    issue(32'h3, 32'h17, 1'b0);
    wait_rsp;
    check("t1_lat", cyc, 66);
    check("t1_do_pulse", do_cnt, 1);
    check("t1_busy", busy_bad, 0);
    check("t1_data", rsp_data, 32'h45);
    check("t1_err", rsp_err, 0);
`ifdef MULT_ISSUE_CTRL_PERF_EN
    check("t1_last_lat", last_lat, 65);
`endif
    respond;
    lat = 5;
    issue(32'h3, 32'h69, 1'b0);
    wait_rsp;
    check("t2_lat", cyc, 7);
    check("t2_data", rsp_data, 32'h13B);
    stable = 1;
    repeat (10) begin
      tick;
      if (rsp_data !== 32'h13B || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || req_ready !== 1'b0) stable = 0;
    end
    check("t2_hold", stable, 1);
    respond;
    check("t2_mul_a", mul_a, 32'h3);
    check("t2_mul_b", mul_b, 32'h69);
    lat = 8;
    stale_s = 1'b1;
    force_u = 1'b1;
    u_xor = 32'hDEAD0000;
    issue(32'hFFFFFFFF, 32'h2, 1'b1);
    repeat (4) tick;
    check("t3_no_stale", rsp_valid, 0);
    stale_s = 1'b0;
    wait_rsp;
    check("t3_lat", cyc, 6);
    check("t3_data", rsp_data, 32'hFFFFFFFE);
    check("t3_err", rsp_err, 0);
    respond;
    force_u = 1'b0;
    u_xor = '0;
    hang = 1'b1;
    issue(32'h5, 32'h7, 1'b0);
    wait_rsp;
    check("t4_lat", cyc, 129);
    check("t4_err", rsp_err, 1);
    check("t4_data", rsp_data, 0);
    check("t4_mul_rst_on", mul_rst, 1);
`ifdef MULT_ISSUE_CTRL_PERF_EN
    check("t4_last_lat", last_lat, 128);
`endif
    tick;
    check("t4_mul_rst_off", mul_rst, 0);
    check("t4_err_held", rsp_err, 1);
    respond;
    hang = 1'b0;
    lat = 20;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (5) tick;
    reset = 1'b0;
    tick;
    check("t5_valid", rsp_valid, 0);
    check("t5_mul_rst", mul_rst, 1);
    check("t5_busy", busy, 0);
    check("t5_mul_a", mul_a, 0);
    reset = 1'b1;
    stable = 1;
    repeat (30) begin
      tick;
      if (rsp_valid !== 1'b0) stable = 0;
    end
    check("t5_no_rsp", stable, 1);
    check("t5_ready", req_ready, 1);
    lat = 3;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_rsp;
    check("t5b_lat", cyc, 5);
    check("t5b_data", rsp_data, 32'h1);
    check("t5b_err", rsp_err, 0);
    respond;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
Issue/capture controller directly upstream of the sequential mult (signed) and multu (unsigned) units. Accepts one multiply request per valid/ready handshake, latches the operands, and pulses doMult for exactly one cycle. It then waits for the selected unit's mult_done, captures the 32-bit product, and presents it on a valid/ready response port. Gives the pipeline a single busy/stall indication and a bounded-latency guarantee via a timeout.

Parameters:
TIMEOUT_CYCLES, 128, maximum WAIT cycles before abort; must be ≥ 2; counter width = $clog2(TIMEOUT_CYCLES+1)
DATA_W, 32, operand/result width; matches mult/multu

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low; sampled on rising clk edge
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_signed  input  1  1 = route to mult, 0 = route to multu
req_a  input  DATA_W  operand A
req_b  input  DATA_W  operand B
mul_a  output  DATA_W  latched A, drives a of both units
mul_b  output  DATA_W  latched B, drives b of both units
mul_do  output  1  doMult to both units, one-cycle pulse
mul_rst  output  1  active-high reset to both units
done_s  input  1  mult_done from mult
done_u  input  1  mult_done from multu
out_s  input  DATA_W  out from mult
out_u  input  DATA_W  out from multu
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  DATA_W  captured product; 0 on timeout
rsp_err  output  1  1 = result is a timeout abort
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset==0 at edge): state=IDLE; mul_a=mul_b=0; mul_do=0; mul_rst=1; rsp_valid=0; rsp_data=0; rsp_err=0; busy=0; counter=0; armed=0. Applies from any state; an in-flight operation is discarded with no response. mul_rst is 0 from the first cycle after reset deasserts.
- req_ready = (state==IDLE) && reset==1; combinational from state only.
- IDLE: on req_valid&&req_ready, latch req_a/req_b/req_signed into mul_a/mul_b/sel; go to LAUNCH.
- LAUNCH (exactly 1 cycle): mul_do=1; counter cleared; armed=0; go to WAIT. mul_do is 0 in every other state.
- WAIT: done = sel ? done_s : done_u; the other unit's done is ignored.
  - armed sets on the first WAIT cycle where done==0. A stale done left high by the previous operation is never accepted.
  - If armed && done: rsp_data <= sel ? out_s : out_u; rsp_err <= 0; go to RESP.
  - Else counter increments. When counter reaches TIMEOUT_CYCLES: rsp_data <= 0, rsp_err <= 1, mul_rst pulses 1 for one cycle, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP: rsp_valid=1; rsp_data/rsp_err held stable until rsp_valid&&rsp_ready. On handshake go to IDLE; rsp_valid drops the next cycle. A new request is accepted at the earliest one cycle later (no IDLE bypass).
- Latency from accepting edge: LAUNCH +1 cycle, response valid = 2 + unit latency + arm cycle(s).
- mul_a/mul_b hold their value from acceptance until the next acceptance, so the units see stable operands throughout.
- No arithmetic in this block. Product is passed unmodified; truncation to DATA_W is the unit's behaviour.

Optional Feature:
MULT_ISSUE_CTRL_PERF_EN: adds output last_lat[15:0], the number of WAIT cycles of the most recent completed or aborted operation. It updates on the WAIT→RESP transition and resets to 0. Without the macro the port and its counter do not exist, and all other behaviour is identical.

Test Plan:
- Unsigned 0x3 × 0x17, model latency 64 → mul_do high exactly 1 cycle; rsp_valid with rsp_data=0x45, rsp_err=0; busy high throughout.
- Unsigned 0x3 × 0x69, rsp_ready held low 10 cycles → rsp_data=0x13B held stable, req_ready=0 until handshake, IDLE one cycle after.
- Signed 0xFFFFFFFF × 0x2 with done_u forced high, done_s stale-high on entry → captures out_s=0xFFFFFFFE only after done_s falls and rises; done_u ignored.
- Model never asserts done, TIMEOUT_CYCLES=128 → after 128 WAIT cycles rsp_err=1, rsp_data=0, mul_rst pulsed 1 cycle.
- reset=0 asserted mid-WAIT (0xFFFFFFFF × 0xFFFFFFFF) → next edge: IDLE, rsp_valid=0, mul_rst=1, no response emitted; next request completes normally.
- With MULT_ISSUE_CTRL_PERF_EN, latency 64 → last_lat equals observed WAIT cycle count; build without the macro compiles and passes all prior cases.
